// File: rtl/imu_burst_reader.sv
// Read sequencer for the IMU: writes the start register over I2C, then reads a burst of
// bytes and emits big-endian 16-bit words. Optional per-byte watchdog: IMU_READ_TIMEOUT_EN.
module imu_burst_reader #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h68,
  parameter logic [7:0] START_REG      = 8'h3B,
  parameter int         NUM_WORDS      = 7,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        i_Clk,
  input  logic        i_rst,
  input  logic        i_Trig,
  output logic        o_Busy,
  output logic [15:0] o_Word,
  output logic [3:0]  o_Word_Idx,
  output logic        o_Word_Valid,
  output logic        o_Frame_Done,
  output logic        o_Error,
  output logic        o_I2C_Ena,
  output logic [6:0]  o_I2C_Slave_Addr,
  output logic        o_I2C_Wr_Start,
  output logic        o_I2C_Rd_Start,
  output logic [7:0]  o_I2C_Wr_Byte,
  input  logic        i_I2C_Busy,
  input  logic [7:0]  i_I2C_Rd_Byte,
  input  logic        i_I2C_Error
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_WAIT, READ, READ_WAIT, DONE, FAIL
  } state_t;

  localparam logic [4:0] LAST_BYTE = 5'(2 * NUM_WORDS - 1);

  if (NUM_WORDS < 1 || NUM_WORDS > 15) begin : g_bad_num_words
    $error("imu_burst_reader: NUM_WORDS must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("imu_burst_reader: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  state_t     state;
  logic       accepted;   // master has raised busy for the current byte
  logic [4:0] byte_cnt;
  logic [7:0] high_byte;

`ifdef IMU_READ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog;
`endif

  assign o_I2C_Slave_Addr = SLAVE_ADDR;
  assign o_I2C_Wr_Byte    = START_REG;

  always_ff @(posedge i_Clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= IDLE;
      accepted       <= 1'b0;
      byte_cnt       <= '0;
      // NOTE: the byte staging register sits in the same async-reset block as the FSM, so it
      // must be reset here too; leaving it out would turn i_rst into a load enable for it.
      high_byte      <= '0;
      o_Busy         <= 1'b0;
      o_Word         <= '0;
      o_Word_Idx     <= '0;
      o_Word_Valid   <= 1'b0;
      o_Frame_Done   <= 1'b0;
      o_Error        <= 1'b0;
      o_I2C_Ena      <= 1'b0;
      o_I2C_Wr_Start <= 1'b0;
      o_I2C_Rd_Start <= 1'b0;
`ifdef IMU_READ_TIMEOUT_EN
      wdog           <= '0;
`endif
    end else begin
      // NOTE: strobes default low every cycle, so each assignment below is a one-cycle pulse.
      o_I2C_Wr_Start <= 1'b0;
      o_I2C_Rd_Start <= 1'b0;
      o_Word_Valid   <= 1'b0;
      o_Frame_Done   <= 1'b0;

      case (state)
        IDLE: begin
          byte_cnt  <= '0;
          o_Busy    <= 1'b0;
          o_I2C_Ena <= 1'b0;
          if (i_Trig) begin
            state          <= ADDR;
            o_Busy         <= 1'b1;
            o_I2C_Ena      <= 1'b1;
            o_Error        <= 1'b0;
            o_I2C_Wr_Start <= 1'b1;
`ifdef IMU_READ_TIMEOUT_EN
            wdog           <= '0;
`endif
          end
        end

        ADDR: begin
          accepted <= 1'b0;
          state    <= ADDR_WAIT;
        end

        READ: begin
          o_I2C_Rd_Start <= 1'b1;
          accepted       <= 1'b0;
          state          <= READ_WAIT;
`ifdef IMU_READ_TIMEOUT_EN
          wdog           <= '0;
`endif
        end

        ADDR_WAIT, READ_WAIT: begin
          // A busy-low cycle before the master has accepted the byte is not a completion.
          if (!accepted) begin
            if (i_I2C_Busy) accepted <= 1'b1;
          end else if (!i_I2C_Busy) begin
            if (i_I2C_Error) begin
              state <= FAIL;
            end else if (state == ADDR_WAIT) begin
              state <= READ;
            end else begin
              if (!byte_cnt[0]) begin
                high_byte <= i_I2C_Rd_Byte;
              end else begin
                o_Word       <= {high_byte, i_I2C_Rd_Byte};
                o_Word_Idx   <= byte_cnt[4:1];
                o_Word_Valid <= 1'b1;
              end
              byte_cnt <= byte_cnt + 5'd1;
              state    <= (byte_cnt == LAST_BYTE) ? DONE : READ;
            end
          end
`ifdef IMU_READ_TIMEOUT_EN
          if (!(accepted && !i_I2C_Busy)) begin
            if (wdog == TIMEOUT_LAST) state <= FAIL;
            else                      wdog  <= wdog + 16'd1;
          end
`endif
        end

        DONE: begin
          o_Frame_Done <= 1'b1;
          state        <= IDLE;
        end

        FAIL: begin
          o_Error <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imu_burst_reader.md
# imu_burst_reader

Read sequencer that sits directly upstream of the I2C byte master in the drone flight controller. On a trigger it writes the IMU start-register address and then reads a burst of bytes one at a time through the master's byte-level start/busy handshake. It packs the bytes into 16-bit big-endian sensor words and presents each word with a one-cycle valid strobe. It also flags I2C errors and stalled transfers to the control logic.

## Interface
- SLAVE_ADDR, 7'h68: 7-bit I2C address of the IMU.
- START_REG, 8'h3B: first register of the burst.
- NUM_WORDS, 7: 16-bit words per frame (1..15); the frame is 2*NUM_WORDS bytes.
- TIMEOUT_CYCLES, 50000: per-byte watchdog limit in i_Clk cycles (16-bit).

Ports:
- i_Clk  in  1  system clock, all logic on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_Trig  in  1  single-cycle frame request.
- o_Busy  out  1  frame in progress.
- o_Word  out  16  assembled word, {high byte, low byte}.
- o_Word_Idx  out  4  index of o_Word within the frame, 0-based.
- o_Word_Valid  out  1  one-cycle strobe qualifying o_Word and o_Word_Idx.
- o_Frame_Done  out  1  one-cycle strobe when a frame completes without error.
- o_Error  out  1  sticky abort flag.
- o_I2C_Ena  out  1  enable to the I2C master.
- o_I2C_Slave_Addr  out  7  constant SLAVE_ADDR.
- o_I2C_Wr_Start  out  1  one-cycle write-byte request.
- o_I2C_Rd_Start  out  1  one-cycle read-byte request.
- o_I2C_Wr_Byte  out  8  write data; always START_REG.
- i_I2C_Busy  in  1  master busy.
- i_I2C_Rd_Byte  in  8  byte read by the master; valid when busy falls.
- i_I2C_Error  in  1  master NACK/arbitration error; sampled when busy falls.

## Operation
- FSM states: IDLE, ADDR, ADDR_WAIT, READ, READ_WAIT, DONE, FAIL.
- IDLE:
  - i_Trig=1 -> ADDR.
  - Clear o_Error and the byte counter.
- ADDR:
  - Pulse o_I2C_Wr_Start for one cycle.
  - -> ADDR_WAIT.
- ADDR_WAIT and READ_WAIT each have two phases:
  - wait for i_I2C_Busy=1 (accepted);
  - then wait for i_I2C_Busy=0 (complete).
  - A busy-low cycle seen before acceptance does not count as completion.
- On completion:
  - i_I2C_Error=1 -> FAIL.
  - From ADDR_WAIT, otherwise -> READ.
  - From READ_WAIT, otherwise capture i_I2C_Rd_Byte:
    - even byte index -> high byte register;
    - odd byte index -> emit word;
    - increment the byte counter;
    - last byte (index 2*NUM_WORDS-1) -> DONE, else -> READ.
- READ:
  - Pulse o_I2C_Rd_Start for one cycle.
  - -> READ_WAIT.
- DONE: pulse o_Frame_Done; -> IDLE.
- FAIL: set o_Error; -> IDLE. o_Frame_Done is not pulsed.
- o_Busy and o_I2C_Ena = 1 in every state except IDLE.
- i_Trig is ignored outside IDLE.
- o_I2C_Wr_Start and o_I2C_Rd_Start are never high in the same cycle.
- Byte counter is 5 bits; o_Word_Idx = byte counter >> 1. There is no wrap within a frame.
- Reset mid-frame returns to IDLE immediately; partial data is discarded and no strobe is emitted.

## Timing
- Reset values:
  - all outputs 0, except o_I2C_Slave_Addr=SLAVE_ADDR and o_I2C_Wr_Byte=START_REG;
  - state IDLE.
- i_Trig sampled at edge N -> o_Busy=1 and o_I2C_Wr_Start=1 during cycle N+1.
- Read completion (busy=0 sampled at edge M) -> o_Word_Valid during cycle M+1. For the next byte, o_I2C_Rd_Start is high in cycle M+2.
- Last word: o_Word_Valid in cycle M+1, then o_Frame_Done with o_Busy still 1 in cycle M+2, then o_Busy=0 in cycle M+3.
- Error at completion edge M: o_Error=1 from cycle M+2; o_Busy=0 in cycle M+3.
- o_Word and o_Word_Idx hold their value until the next word.

## Configuration
- IMU_READ_TIMEOUT_EN defined:
  - A 16-bit watchdog clears on every start pulse and counts every cycle in ADDR_WAIT and READ_WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion -> FAIL, which is identical to an I2C error.
- IMU_READ_TIMEOUT_EN undefined: no watchdog logic; the FSM waits indefinitely.

## Test plan
- Nominal frame: model accepts each start after 3 cycles and completes after 20 cycles, returning bytes 0x01..0x0E. Required: 7 strobes with words 0x0102, 0x0304, ... 0x0D0E and indices 0..6, then exactly one o_Frame_Done; o_Error=0.
- Address NACK: i_I2C_Error=1 when the write completes. Required: no o_I2C_Rd_Start, o_Error=1, no o_Frame_Done; o_Busy=0 three cycles after the busy fall.
- Mid-frame read error on byte 5. Required: strobes only for indices 0 and 1, then o_Error=1. A new i_Trig clears o_Error and re-issues the write.
- i_Trig pulsed repeatedly during a frame. Required: no extra start pulses; the frame completes normally.
- Reset asserted during READ_WAIT. Required: all outputs at reset values asynchronously; no o_Word_Valid after release.
- With IMU_READ_TIMEOUT_EN, TIMEOUT_CYCLES=100, busy held high forever. Required: o_Error=1 about 100 cycles after acceptance. Without the macro, o_Busy stays 1.
